// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, types and glyph table for the LCD text renderer.
// Latency: n/a (package only).
// Backpressure: n/a.
package lcd_pkg;

  localparam int TEXT_COLS = 40;
  localparam int TEXT_ROWS = 25;
  localparam int GLYPH_W   = 8;
  localparam int GLYPH_H   = 8;

  // Default 480x272 panel timing, in pixels (horizontal) and lines (vertical).
  localparam int LCD_H_ACTIVE = 480;
  localparam int LCD_H_FP     = 2;
  localparam int LCD_H_SYNC   = 41;
  localparam int LCD_H_BP     = 2;
  localparam int LCD_V_ACTIVE = 272;
  localparam int LCD_V_FP     = 2;
  localparam int LCD_V_SYNC   = 10;
  localparam int LCD_V_BP     = 2;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam rgb565_t COLOR_FG = '{r: 5'd31, g: 6'd63, b: 5'd31};
  localparam rgb565_t COLOR_BG = '{r: 5'd0,  g: 6'd0,  b: 5'd0};

  // Per-pixel side information carried alongside the VRAM/font data.
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       txt;
    logic       cur;
    logic [2:0] x;
    logic [2:0] y;
  } pix_meta_t;

  // Idle meta: syncs inactive (high), nothing visible.
  localparam pix_meta_t META_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, txt: 1'b0,
                                      cur: 1'b0, x: 3'd0, y: 3'd0};

  // Glyph table: space is blank, 'A' is a real glyph, every other code gets a
  // fixed filler pattern so all 128 codes render something distinguishable.
  function automatic logic [7:0] glyph_row(input logic [6:0] code, input logic [2:0] row);
    case (code)
      7'h20: glyph_row = 8'h00;
      7'h41: begin
        case (row)
          3'd0:    glyph_row = 8'h18;
          3'd1:    glyph_row = 8'h3C;
          3'd2:    glyph_row = 8'h66;
          3'd3:    glyph_row = 8'h66;
          3'd4:    glyph_row = 8'h7E;
          3'd5:    glyph_row = 8'h66;
          3'd6:    glyph_row = 8'h66;
          default: glyph_row = 8'h00;
        endcase
      end
      default: glyph_row = {code[3:0], code[6:4], 1'b0} ^ {row, row, row[2:1]};
    endcase
  endfunction

endpackage

// File: rtl/font_rom.sv
// font_rom: 1024x8 glyph ROM (128 codes x 8 rows), address {code, row}; contents from lcd_pkg::glyph_row.
// Latency: 1 clk, registered output.
// Backpressure: none; a lookup every cycle.
module font_rom
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] addr,
  output logic [7:0] data
);

  // Registered ROM read; table is synthesised from the package function.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data <= 8'h00;
    else        data <= glyph_row(addr[9:3], addr[2:0]);
  end

endmodule

// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl: scans 40x25 text VRAM on BSRAM port B and drives an RGB565 LCD with 8x8 glyphs.
// Latency: 4 clk from raster counter to pins (S0 addr, S1/S2 BSRAM, S3 font ROM, S4 output reg).
// Backpressure: none; free-running raster, port B read every cycle. Option macro: LCD_CURSOR_EN (blinking cursor).
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = LCD_H_ACTIVE,
  parameter int H_FP     = LCD_H_FP,
  parameter int H_SYNC   = LCD_H_SYNC,
  parameter int H_BP     = LCD_H_BP,
  parameter int V_ACTIVE = LCD_V_ACTIVE,
  parameter int V_FP     = LCD_V_FP,
  parameter int V_SYNC   = LCD_V_SYNC,
  parameter int V_BP     = LCD_V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] v_adb,
  output logic       v_ceb,
  output logic       v_oce,
  input  logic [7:0] v_dout,
  input  logic [9:0] cursor_pos,
  output logic       lcd_de,
  output logic       lcd_hsync,
  output logic       lcd_vsync,
  output logic [4:0] lcd_r,
  output logic [5:0] lcd_g,
  output logic [4:0] lcd_b
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] TXT_W    = 10'(TEXT_COLS * GLYPH_W);
  localparam logic [9:0] TXT_H    = 10'(TEXT_ROWS * GLYPH_H);

  logic [9:0] hcnt, vcnt;
  logic       h_last, v_last;

  assign h_last = (hcnt == H_LAST);
  assign v_last = (vcnt == V_LAST);

  // Free-running raster counters; line and frame wrap land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? 10'd0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  logic       in_text;
  logic [4:0] text_row;
  logic [5:0] text_col;
  logic [9:0] addr;
  logic       cur_hit;
  pix_meta_t  meta0;

  // S0: cell address row*40+col as shift-add; zero outside the text area.
  always_comb begin
    in_text  = (hcnt < TXT_W) && (vcnt < TXT_H);
    text_row = vcnt[7:3];
    text_col = hcnt[8:3];
    addr     = '0;
    if (in_text) addr = {text_row, 5'd0} + {2'd0, text_row, 3'd0} + {4'd0, text_col};
  end

`ifdef LCD_CURSOR_EN
  logic [5:0] frame_cnt;

  // Frame counter; bit 5 gives the 32-on/32-off cursor blink.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                frame_cnt <= '0;
    else if (h_last && v_last) frame_cnt <= frame_cnt + 6'd1;
  end

  assign cur_hit = in_text && (addr == cursor_pos) && frame_cnt[5];
`else
  logic unused_cursor;
  assign unused_cursor = ^cursor_pos;
  assign cur_hit       = 1'b0;
`endif

  // S0: timing flags and sub-cell coordinates that travel with the read.
  always_comb begin
    meta0     = META_IDLE;
    meta0.de  = (hcnt < H_ACT) && (vcnt < V_ACT);
    meta0.hs  = !((hcnt >= HS_START) && (hcnt < HS_END));
    meta0.vs  = !((vcnt >= VS_START) && (vcnt < VS_END));
    meta0.txt = in_text;
    meta0.cur = cur_hit;
    meta0.x   = hcnt[2:0];
    meta0.y   = vcnt[2:0];
  end

  // Port B is read every cycle; enables drop only while reset is held.
  assign v_adb = addr;
  assign v_ceb = rst_n;
  assign v_oce = rst_n;

  pix_meta_t meta1, meta2, meta3;
  logic      inv3;
  logic [7:0] glyph;

  // S1..S3: delay side information to match the 2-cycle BSRAM and the font ROM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta1 <= META_IDLE;
      meta2 <= META_IDLE;
      meta3 <= META_IDLE;
      inv3  <= 1'b0;
    end else begin
      meta1 <= meta0;
      meta2 <= meta1;
      meta3 <= meta2;
      inv3  <= v_dout[7];
    end
  end

  font_rom u_font_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  ({v_dout[6:0], meta2.y}),
    .data  (glyph)
  );

  logic    pix_on;
  rgb565_t rgb_q;

  // S4: pick the glyph bit (MSB is leftmost), apply inverse and cursor.
  always_comb begin
    pix_on = glyph[3'd7 - meta3.x] ^ inv3 ^ meta3.cur;
  end

  // S4: output register; blanking and non-text pixels are background.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_de    <= 1'b0;
      lcd_hsync <= 1'b1;
      lcd_vsync <= 1'b1;
      rgb_q     <= COLOR_BG;
    end else begin
      lcd_de    <= meta3.de;
      lcd_hsync <= meta3.hs;
      lcd_vsync <= meta3.vs;
      rgb_q     <= (meta3.de && meta3.txt && pix_on) ? COLOR_FG : COLOR_BG;
    end
  end

  assign lcd_r = rgb_q.r;
  assign lcd_g = rgb_q.g;
  assign lcd_b = rgb_q.b;

endmodule
